motoro3_step_sequencer: RTL
===========================

MOTORO3_STEP_SEQUENCER -- requirements
Module: motoro3_step_sequencer

Interface
REQ-001 The module SHALL have exactly one clock; reset SHALL be synchronous and active-high.
REQ-002 The module SHALL have port clk, input, 1 bit: system clock, 10 MHz.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: one-cycle start request.
REQ-005 The module SHALL have port stop, input, 1 bit: one-cycle stop request.
REQ-006 The module SHALL have port dir, input, 1 bit: rotation direction, 1 = forward, 0 = reverse.
REQ-007 The module SHALL have port m3r_align_len, input, 25 bits: alignment hold time in clk cycles.
REQ-008 The module SHALL have port m3r_ramp_reload, input, 25 bits: step reload value at the start of the ramp (slowest speed).
REQ-009 The module SHALL have port m3r_step_cnt_reload1, input, 25 bits: target step reload value (run speed).
REQ-010 The module SHALL have port m3r_ramp_dec, input, 16 bits: amount the reload value drops at each ramp step boundary.
REQ-011 The module SHALL have port m3cnt, output, 25 bits: step down-counter.
REQ-012 The module SHALL have port m3cntLast1, output, 1 bit: high while m3cnt == 1.
REQ-013 The module SHALL have ports stepU, stepV and stepW, output, 4 bits each: per-phase line-generator step codes.
REQ-014 The module SHALL have port running, output, 1 bit: high in RUN state only.
REQ-015 The module SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ALIGN, RAMP and RUN.
REQ-017 Step code SHALL be:
- 0..5 = commutation step;
- 4'hF = phase off.
- In IDLE, stepU, stepV and stepW SHALL all be 4'hF.
REQ-018 Outside IDLE, the phase codes SHALL be derived from the internal step s (0..5):
- stepU = s;
- stepV = (s+4) mod 6;
- stepW = (s+2) mod 6.
REQ-019 In IDLE, start (with stop low) SHALL cause the following on the next cycle:
- state = ALIGN;
- s = 0;
- m3cnt = max(m3r_align_len, 1);
- dir latched.
- start outside IDLE SHALL be ignored.
REQ-020 Outside IDLE, m3cnt SHALL decrement by 1 per cycle. The cycle after m3cnt == 0 is a "boundary": m3cnt reloads and the FSM acts as in REQ-021..REQ-023.
REQ-021 At the ALIGN boundary:
- if m3r_ramp_reload <= m3r_step_cnt_reload1, go to RUN with curReload = target;
- otherwise, go to RAMP with curReload = m3r_ramp_reload.
- s SHALL advance once.
- m3cnt SHALL load max(curReload, 1).
REQ-022 At each RAMP boundary:
- curReload SHALL become max(curReload - m3r_ramp_dec, target), with no unsigned underflow;
- s SHALL advance;
- m3cnt SHALL load max(new curReload, 1);
- once the new curReload equals target, state SHALL become RUN.
REQ-023 At each RUN boundary:
- curReload SHALL be resampled from m3r_step_cnt_reload1, so target changes take effect only at boundaries;
- s SHALL advance;
- m3cnt SHALL load max(curReload, 1).
REQ-024 Step advance SHALL be mod 6 and follow the latched dir:
- forward: 5 -> 0;
- reverse: 0 -> 5.
REQ-025 Step period SHALL be max(reload, 1) + 1 cycles. The minimum step period SHALL be 2 cycles.
REQ-026 stop asserted in any non-IDLE state SHALL cause the following on the next cycle:
- state = IDLE;
- m3cnt = 0;
- steps = 4'hF.
- stop SHALL win over start and over a coincident boundary.
REQ-027 m3cntLast1 SHALL be combinational from m3cnt: high iff m3cnt == 1, and low in IDLE.
REQ-028 m3r_* inputs SHALL be sampled only at the state-entry and boundary points stated above. Mid-step changes SHALL not alter the current m3cnt.

Reset
REQ-029 rst high at a clk edge SHALL set:
- state = IDLE;
- m3cnt = 0;
- curReload = 0;
- s = 0;
- latched dir = 1;
- stepU/V/W = 4'hF;
- running = 0;
- busy = 0.
REQ-030 rst SHALL override start, stop and all state activity, including mid-step or mid-ramp.

Verification
REQ-031 Bench SHALL check ALIGN then RAMP:
- Stimulus: align_len = 3, ramp_reload = 10, target = 4, ramp_dec = 3, dir = 1, start pulse.
- Required response: ALIGN for 4 cycles with steps U0/V4/W2; RAMP reloads 7 then 4; RUN entered at the second ramp boundary; s sequence 1, 2, 3, ...
REQ-032 Bench SHALL check reverse wrap:
- Stimulus: dir = 0 at start, ramp_reload = target = 2.
- Required response: after ALIGN, s = 5, 4, 3, ...; every step lasts 3 cycles; running = 1.
REQ-033 Bench SHALL check stop mid-ramp coinciding with m3cnt == 0:
- Required response: next cycle IDLE, m3cnt = 0, all steps 4'hF, busy = 0; no step advance.
REQ-034 Bench SHALL check a target change in RUN:
- Stimulus: change target 4 -> 9 while m3cnt = 2.
- Required response: the current step ends on schedule; the next m3cnt load is 9.
REQ-035 Bench SHALL check zero reloads:
- Stimulus: align_len = 0, target = 0.
- Required response: ALIGN lasts 2 cycles; m3cntLast1 pulses every 2 cycles in RUN.
REQ-036 Bench SHALL check reset during RUN:
- Stimulus: rst = 1 for 1 cycle.
- Required response: all REQ-029 values hold on the next cycle; start and stop in the same cycle as rst are ignored.

Source files
------------

// File: rtl/motoro3_step_sequencer.sv
// Three-phase step sequencer: align hold, linear reload ramp, then steady run.
// Registered outputs except step codes/flags, which decode the current state; stop and rst win over everything.
module motoro3_step_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        dir,
  input  logic [24:0] m3r_align_len,
  input  logic [24:0] m3r_ramp_reload,
  input  logic [24:0] m3r_step_cnt_reload1,
  input  logic [15:0] m3r_ramp_dec,
  output logic [24:0] m3cnt,
  output logic        m3cntLast1,
  output logic [3:0]  stepU,
  output logic [3:0]  stepV,
  output logic [3:0]  stepW,
  output logic        running,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RAMP  = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  state_t      r_state;
  logic [24:0] r_cnt;
  logic [24:0] r_cur_reload;
  logic [2:0]  r_step;
  logic        r_dir;

  state_t      w_state_nxt;
  logic [24:0] w_cnt_nxt;
  logic [24:0] w_cur_nxt;
  logic [2:0]  w_step_nxt;
  logic        w_dir_nxt;

  logic [2:0]  w_step_adv;
  logic [24:0] w_dec_ext;
  logic [24:0] w_ramp_diff;
  logic [24:0] w_ramp_next;

  function automatic logic [24:0] f_min1(input logic [24:0] v);
    f_min1 = (v == 25'd0) ? 25'd1 : v;
  endfunction

  assign w_step_adv = r_dir ? ((r_step == 3'd5) ? 3'd0 : r_step + 3'd1)
                            : ((r_step == 3'd0) ? 3'd5 : r_step - 3'd1);

  // Saturate at zero before clamping to the target so a large decrement never wraps.
  assign w_dec_ext   = {9'd0, m3r_ramp_dec};
  assign w_ramp_diff = (r_cur_reload >= w_dec_ext) ? (r_cur_reload - w_dec_ext) : 25'd0;
  assign w_ramp_next = (w_ramp_diff > m3r_step_cnt_reload1) ? w_ramp_diff : m3r_step_cnt_reload1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 25'd0;
      r_cur_reload <= 25'd0;
      r_step       <= 3'd0;
      r_dir        <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_cur_reload <= w_cur_nxt;
      r_step       <= w_step_nxt;
      r_dir        <= w_dir_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cur_nxt   = r_cur_reload;
    w_step_nxt  = r_step;
    w_dir_nxt   = r_dir;
    if (r_state == ST_IDLE) begin
      if (start && !stop) begin
        w_state_nxt = ST_ALIGN;
        w_step_nxt  = 3'd0;
        w_cnt_nxt   = f_min1(m3r_align_len);
        w_dir_nxt   = dir;
      end
    end else if (stop) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 25'd0;
    end else if (r_cnt != 25'd0) begin
      w_cnt_nxt = r_cnt - 25'd1;
    end else begin
      w_step_nxt = w_step_adv;
      case (r_state)
        ST_ALIGN: begin
          if (m3r_ramp_reload <= m3r_step_cnt_reload1) begin
            w_state_nxt = ST_RUN;
            w_cur_nxt   = m3r_step_cnt_reload1;
          end else begin
            w_state_nxt = ST_RAMP;
            w_cur_nxt   = m3r_ramp_reload;
          end
          w_cnt_nxt = f_min1(w_cur_nxt);
        end
        ST_RAMP: begin
          w_cur_nxt = w_ramp_next;
          w_cnt_nxt = f_min1(w_ramp_next);
          if (w_ramp_next == m3r_step_cnt_reload1) begin
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          w_cur_nxt = m3r_step_cnt_reload1;
          w_cnt_nxt = f_min1(m3r_step_cnt_reload1);
        end
      endcase
    end
  end

  assign m3cnt      = r_cnt;
  assign busy       = (r_state != ST_IDLE);
  assign running    = (r_state == ST_RUN);
  assign m3cntLast1 = busy && (r_cnt == 25'd1);

  // Phases are spaced by two steps: V trails U by 2, W leads U by 2 (mod 6).
  always_comb begin
    stepU = 4'hF;
    stepV = 4'hF;
    stepW = 4'hF;
    if (busy) begin
      stepU = {1'b0, r_step};
      stepV = (r_step >= 3'd2) ? {1'b0, r_step - 3'd2} : {1'b0, r_step + 3'd4};
      stepW = (r_step >= 3'd4) ? {1'b0, r_step - 3'd4} : {1'b0, r_step + 3'd2};
    end
  end

endmodule
